// File: rtl/ysyx_22050019_mul_iter_unit_if.sv
// Multiply request/stall/result handshake between the EXU ALU (master) and
// the iterative multiplier (slave).
interface ysyx_22050019_mul_iter_unit_if #(
    parameter int XLEN = 64
);
    logic            mult_valid;
    logic [4:0]      mult_type;
    logic [XLEN-1:0] multiplicand_i;
    logic [XLEN-1:0] multiplier_i;
    logic            result_ready;
    logic [XLEN-1:0] mult_out;
    logic            mult_stall;
    logic            result_ok;

    modport master (
        output mult_valid, mult_type, multiplicand_i, multiplier_i, result_ready,
        input  mult_out, mult_stall, result_ok
    );

    modport slave (
        input  mult_valid, mult_type, multiplicand_i, multiplier_i, result_ready,
        output mult_out, mult_stall, result_ok
    );
endinterface

// File: rtl/ysyx_22050019_mul_iter_unit.sv
// Iterative shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Signed ops multiply magnitudes and negate the 128-bit product at the end.
module ysyx_22050019_mul_iter_unit #(
    parameter int XLEN = 64,
    parameter int W32  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    ysyx_22050019_mul_iter_unit_if.slave        mif
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;
    typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW} op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d, op_s;
    logic                neg_q, neg_d, neg_s;
    logic [6:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]     mcand_q, mcand_d, mplier_q, mplier_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                req_s;
    logic [XLEN-1:0]     a_raw_s, b_raw_s, a_mag_s, b_mag_s;
    logic [XLEN:0]       sum_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [6:0]          last_cnt_s;

    assign req_s = mif.mult_valid & (|mif.mult_type);

    // Decode the op (lowest set type bit wins) and form operand magnitudes and sign
    always_comb begin
        op_s = OP_MUL;
        if (mif.mult_type[0]) begin
            op_s = OP_MUL;
        end else if (mif.mult_type[1]) begin
            op_s = OP_MULH;
        end else if (mif.mult_type[2]) begin
            op_s = OP_MULHSU;
        end else if (mif.mult_type[3]) begin
            op_s = OP_MULHU;
        end else if (mif.mult_type[4]) begin
            op_s = OP_MULW;
        end else begin
            op_s = OP_MUL;
        end

        a_raw_s = mif.multiplicand_i;
        b_raw_s = mif.multiplier_i;
        if (op_s == OP_MULW) begin
            a_raw_s = {{(XLEN-W32){1'b0}}, mif.multiplicand_i[W32-1:0]};
            b_raw_s = {{(XLEN-W32){1'b0}}, mif.multiplier_i[W32-1:0]};
        end else begin
            a_raw_s = mif.multiplicand_i;
            b_raw_s = mif.multiplier_i;
        end

        // Negating 0x8000... yields itself, which read unsigned is exactly 2^63.
        a_mag_s = a_raw_s;
        b_mag_s = b_raw_s;
        neg_s   = 1'b0;
        case (op_s)
            OP_MULH: begin
                a_mag_s = a_raw_s[XLEN-1] ? (~a_raw_s + {{(XLEN-1){1'b0}}, 1'b1}) : a_raw_s;
                b_mag_s = b_raw_s[XLEN-1] ? (~b_raw_s + {{(XLEN-1){1'b0}}, 1'b1}) : b_raw_s;
                neg_s   = a_raw_s[XLEN-1] ^ b_raw_s[XLEN-1];
            end
            OP_MULHSU: begin
                a_mag_s = a_raw_s[XLEN-1] ? (~a_raw_s + {{(XLEN-1){1'b0}}, 1'b1}) : a_raw_s;
                neg_s   = a_raw_s[XLEN-1];
            end
            default: begin
                a_mag_s = a_raw_s;
                b_mag_s = b_raw_s;
                neg_s   = 1'b0;
            end
        endcase
    end

    // Datapath helpers: one shift-add step, final sign fix and iteration bound
    always_comb begin
        sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]}
              + (mplier_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        if (neg_q) begin
            prod_fix_s = ~prod_q + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_fix_s = prod_q;
        end
        if (op_q == OP_MULW) begin
            last_cnt_s = 7'(W32 - 1);
        end else begin
            last_cnt_s = 7'(XLEN - 1);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    op_d     = op_s;
                    neg_d    = neg_s;
                    mcand_d  = a_mag_s;
                    mplier_d = b_mag_s;
                    prod_d   = {(2*XLEN){1'b0}};
                    cnt_d    = 7'd0;
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!mif.mult_valid) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d   = {sum_s, prod_q[XLEN-1:1]};
                    mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                    cnt_d    = cnt_q + 7'd1;
                    if (cnt_q == last_cnt_s) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_FIX: begin
                if (!mif.mult_valid) begin
                    state_d = S_IDLE;
                end else begin
                    // After W32 steps a MULW product sits 32 bits up in the accumulator.
                    case (op_q)
                        OP_MUL:  result_d = prod_fix_s[XLEN-1:0];
                        OP_MULW: result_d = {{(XLEN-W32){prod_fix_s[XLEN-1]}},
                                             prod_fix_s[XLEN-1:XLEN-W32]};
                        default: result_d = prod_fix_s[2*XLEN-1:XLEN];
                    endcase
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (mif.result_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= 7'd0;
            mcand_q  <= {XLEN{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            prod_q   <= {(2*XLEN){1'b0}};
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    // Output decode; mult_out is zero outside DONE because it is ORed with the divider
    always_comb begin
        mif.result_ok  = (state_q == S_DONE);
        mif.mult_stall = ((state_q == S_IDLE) & req_s) | (state_q == S_BUSY) | (state_q == S_FIX);
        if (state_q == S_DONE) begin
            mif.mult_out = result_q;
        end else begin
            mif.mult_out = {XLEN{1'b0}};
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_mul_iter_unit.sv
// Directed bench with a scoreboard: the driver pushes expected results and the
// cycle they should appear; a monitor pops and compares when result_ok rises.
module tb_ysyx_22050019_mul_iter_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    logic        prev_ok = 1'b0;
    logic [63:0] held_v = 64'd0;

    ysyx_22050019_mul_iter_unit_if #(.XLEN(64)) mif ();

    ysyx_22050019_mul_iter_unit #(.XLEN(64), .W32(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: result presentation, hold stability, and zero output otherwise
    always @(negedge clk) begin
        if (mif.result_ok === 1'b1) begin
            if (!prev_ok) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    held_v = exp_q.pop_front();
                    chk("result_data", mif.mult_out, held_v);
                    chk("result_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                end
            end else begin
                chk("result_hold", mif.mult_out, held_v);
            end
        end else begin
            chk("out_zero_idle", mif.mult_out, 64'd0);
        end
        prev_ok = (mif.result_ok === 1'b1);
    end

    task automatic run_op(input logic [4:0] typ, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input int hold);
        int t;
        @(posedge clk); #1;
        mif.mult_valid = 1'b1;
        mif.mult_type = typ;
        mif.multiplicand_i = a;
        mif.multiplier_i = b;
        t = cyc;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(t + lat);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("stall_busy", {63'd0, mif.mult_stall}, 64'd1);
            chk("ok_low_busy", {63'd0, mif.result_ok}, 64'd0);
            @(posedge clk); #1;
            mif.multiplicand_i = {$urandom, $urandom};
            mif.multiplier_i = {$urandom, $urandom};
        end
        if (hold > 0) mif.result_ready = 1'b0;
        @(negedge clk);
        chk("ok_at_latency", {63'd0, mif.result_ok}, 64'd1);
        chk("stall_done", {63'd0, mif.mult_stall}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("ok_backpressure", {63'd0, mif.result_ok}, 64'd1);
            chk("stall_backpressure", {63'd0, mif.mult_stall}, 64'd0);
        end
        mif.mult_valid = 1'b0;
        mif.result_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ok_after_release", {63'd0, mif.result_ok}, 64'd0);
        chk("out_after_release", mif.mult_out, 64'd0);
    endtask

    initial begin
        int t;
        mif.mult_valid = 1'b0;
        mif.mult_type = 5'd0;
        mif.multiplicand_i = 64'd0;
        mif.multiplier_i = 64'd0;
        mif.result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_ok", {63'd0, mif.result_ok}, 64'd0);
        chk("reset_stall", {63'd0, mif.mult_stall}, 64'd0);
        chk("reset_out", mif.mult_out, 64'd0);

        run_op(5'b00001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66, 0);
        run_op(5'b00010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 66, 0);
        run_op(5'b01000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        run_op(5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, 0);
        run_op(5'b00100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        run_op(5'b10000, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        // Multiple type bits: MULH (bit 1) beats MULHU (bit 3)
        run_op(5'b01010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, 0);
        // Backpressure: 5 cycles with result_ready low
        run_op(5'b00001, 64'd1000, 64'd1000, 64'd1000000, 66, 5);

        // Reset during BUSY aborts without a result
        @(posedge clk); #1;
        mif.mult_valid = 1'b1;
        mif.mult_type = 5'b00001;
        mif.multiplicand_i = 64'd5;
        mif.multiplier_i = 64'd9;
        t = cyc;
        while (cyc < t + 20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        mif.mult_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ok", {63'd0, mif.result_ok}, 64'd0);
        chk("rst_mid_stall", {63'd0, mif.mult_stall}, 64'd0);
        chk("rst_mid_out", mif.mult_out, 64'd0);
        run_op(5'b00001, 64'd7, 64'd6, 64'd42, 66, 0);

        // mult_valid dropped at T+10 aborts
        @(posedge clk); #1;
        mif.mult_valid = 1'b1;
        mif.mult_type = 5'b00001;
        mif.multiplicand_i = 64'd11;
        mif.multiplier_i = 64'd13;
        t = cyc;
        while (cyc < t + 10) begin
            @(posedge clk); #1;
        end
        mif.mult_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall_t10", {63'd0, mif.mult_stall}, 64'd1);
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_stall", {63'd0, mif.mult_stall}, 64'd0);
            chk("abort_ok", {63'd0, mif.result_ok}, 64'd0);
        end

        // Valid with no type bit is not a request
        @(posedge clk); #1;
        mif.mult_valid = 1'b1;
        mif.mult_type = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("notype_stall", {63'd0, mif.mult_stall}, 64'd0);
            chk("notype_ok", {63'd0, mif.result_ok}, 64'd0);
            @(posedge clk); #1;
        end
        mif.mult_valid = 1'b0;

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
